// File: rtl/lwe_row_accumulator_if.sv
// Row-in and ciphertext-out handshake bundle for lwe_row_accumulator.
// master = upstream key cache / downstream output stage side, slave = accumulator.
interface lwe_row_accumulator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COLS   = 4
);
    logic                           row_valid;
    logic                           row_ready;
    logic [NUM_COLS*DATA_WIDTH-1:0] row_in;
    logic [15:0]                    sum_in;
    logic                           select;
    logic                           ct_valid;
    logic                           ct_ready;
    logic [NUM_COLS*DATA_WIDTH-1:0] ct_a;
    logic [15:0]                    ct_b;

    modport master (
        output row_valid, row_in, sum_in, select, ct_ready,
        input  row_ready, ct_valid, ct_a, ct_b
    );

    modport slave (
        input  row_valid, row_in, sum_in, select, ct_ready,
        output row_ready, ct_valid, ct_a, ct_b
    );
endinterface

// File: rtl/lwe_row_accumulator.sv
// Accumulates NUM_ROWS selected public-key rows into an LWE ciphertext (ct_a, ct_b).
// Optional LWE_ACC_SEL_COUNT_EN adds a sel_count output counting selected rows.
module lwe_row_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROWS   = 8,
    parameter int NUM_COLS   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] kyber_k,
    input  logic       msg_bit,
    output logic       busy,
`ifdef LWE_ACC_SEL_COUNT_EN
    output logic [$clog2(NUM_ROWS+1)-1:0] sel_count,
`endif
    lwe_row_accumulator_if.slave bus
);
    localparam int CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

    state_t                                 state_q, state_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [NUM_COLS-1:0][DATA_WIDTH-1:0]    acc_a_q, acc_a_d;
    logic [15:0]                            acc_b_q, acc_b_d;
    logic [2:0]                             k_q, k_d;
    logic                                   msg_q, msg_d;
    logic                                   row_ready;
    logic                                   ct_valid;
`ifdef LWE_ACC_SEL_COUNT_EN
    logic [$clog2(NUM_ROWS+1)-1:0]          sel_cnt_q, sel_cnt_d;
`endif

    function automatic logic [DATA_WIDTH-1:0] add_lane(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return a + b;
    endfunction

    function automatic logic [15:0] add_b(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

    // k == 3 restricts the row to lanes 0..2; every other k uses all lanes.
    function automatic logic lane_active(input logic [2:0] k, input int c);
        return (k == 3'd3) ? (c < 3) : 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        k_d       = k_q;
        msg_d     = msg_q;
        row_ready = 1'b0;
        ct_valid  = 1'b0;
`ifdef LWE_ACC_SEL_COUNT_EN
        sel_cnt_d = sel_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_a_d = '0;
                    acc_b_d = '0;
                    cnt_d   = '0;
                    k_d     = kyber_k;
                    msg_d   = msg_bit;
`ifdef LWE_ACC_SEL_COUNT_EN
                    sel_cnt_d = '0;
`endif
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                row_ready = 1'b1;
                if (bus.row_valid) begin
                    if (bus.select) begin
                        for (int c = 0; c < NUM_COLS; c++) begin
                            if (lane_active(k_q, c)) begin
                                acc_a_d[c] = add_lane(acc_a_q[c],
                                                      bus.row_in[c*DATA_WIDTH +: DATA_WIDTH]);
                            end
                        end
                        acc_b_d = add_b(acc_b_q, bus.sum_in);
`ifdef LWE_ACC_SEL_COUNT_EN
                        sel_cnt_d = sel_cnt_q + 1'b1;
`endif
                    end
                    // Leaving on the last row keeps the counter from wrapping.
                    if (cnt_q == LAST_ROW) begin
                        state_d = FINAL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FINAL: begin
                acc_b_d = add_b(acc_b_q, {msg_q, 15'b0});
                state_d = DONE;
            end
            DONE: begin
                ct_valid = 1'b1;
                if (bus.ct_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_a_q <= '0;
            acc_b_q <= '0;
            k_q     <= '0;
            msg_q   <= 1'b0;
`ifdef LWE_ACC_SEL_COUNT_EN
            sel_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            k_q     <= k_d;
            msg_q   <= msg_d;
`ifdef LWE_ACC_SEL_COUNT_EN
            sel_cnt_q <= sel_cnt_d;
`endif
        end
    end

    assign bus.row_ready = row_ready;
    assign bus.ct_valid  = ct_valid;
    assign bus.ct_a      = acc_a_q;
    assign bus.ct_b      = acc_b_q;
    assign busy          = (state_q != IDLE);
`ifdef LWE_ACC_SEL_COUNT_EN
    assign sel_count     = sel_cnt_q;
`endif

endmodule

// File: tb/tb_lwe_row_accumulator.sv
// Directed bench for lwe_row_accumulator: full, partial, wrap, backpressure,
// mid-operation reset and back-to-back encryptions with hand-computed results.
module tb_lwe_row_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] kyber_k;
    logic       msg_bit;
    logic       busy;
`ifdef LWE_ACC_SEL_COUNT_EN
    logic [3:0] sel_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] FULL_A    = {16'h0034, 16'h002C, 16'h0024, 16'h001C};
    localparam logic [15:0] FULL_B    = 16'h001C;
    localparam logic [63:0] PART_A    = {16'h0000, 16'h0014, 16'h0010, 16'h000C};
    localparam logic [15:0] PART_B    = 16'h800C;
    localparam logic [63:0] WRAP_A    = {4{16'hFFF8}};

    lwe_row_accumulator_if #(.DATA_WIDTH(16), .NUM_COLS(4)) bus ();

    lwe_row_accumulator #(.DATA_WIDTH(16), .NUM_ROWS(8), .NUM_COLS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kyber_k  (kyber_k),
        .msg_bit  (msg_bit),
        .busy     (busy),
`ifdef LWE_ACC_SEL_COUNT_EN
        .sel_count(sel_count),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A row beat offered alongside start must be ignored (row_ready is low in IDLE).
    task automatic do_start(input logic [2:0] k, input logic msg);
        start         = 1'b1;
        kyber_k       = k;
        msg_bit       = msg;
        bus.row_valid = 1'b1;
        bus.row_in    = {4{16'h1111}};
        bus.sum_in    = 16'h1111;
        bus.select    = 1'b1;
        tick();
        start         = 1'b0;
        bus.row_valid = 1'b0;
    endtask

    task automatic feed_rows(input int n, input bit wrap, input logic [7:0] sel, input bit stress);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < n && guard < 200) begin
            if (stress && $urandom_range(0, 2) == 0) begin
                bus.row_valid = 1'b0;
            end else begin
                bus.row_valid = 1'b1;
                for (int c = 0; c < 4; c++)
                    bus.row_in[c*16 +: 16] = wrap ? 16'hFFFF : 16'(i + c);
                bus.sum_in = wrap ? 16'hFFFF : 16'(i);
                bus.select = sel[i];
            end
            start = stress && (i == 3);
            acc = bus.row_valid && bus.row_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        bus.row_valid = 1'b0;
        start         = 1'b0;
        if (i != n) check("feed_timeout", i, n);
    endtask

    task automatic run_enc(input string tag, input logic [2:0] k, input logic msg, input bit wrap,
                           input logic [7:0] sel, input bit stress,
                           input logic [63:0] exp_a, input logic [15:0] exp_b);
        bus.ct_ready = !stress;
        do_start(k, msg);
        check({tag, "_busy"}, busy, 1);
        feed_rows(8, wrap, sel, stress);
        check({tag, "_valid_early"}, bus.ct_valid, 0);
        tick();
        check({tag, "_valid"}, bus.ct_valid, 1);
        check({tag, "_ct_a"}, bus.ct_a, exp_a);
        check({tag, "_ct_b"}, bus.ct_b, exp_b);
`ifdef LWE_ACC_SEL_COUNT_EN
        check({tag, "_sel_count"}, sel_count, $countones(sel));
`endif
        if (stress) begin
            for (int j = 0; j < 5; j++) begin
                start = (j == 2);
                tick();
                check({tag, "_hold_valid"}, bus.ct_valid, 1);
                check({tag, "_hold_a"}, bus.ct_a, exp_a);
                check({tag, "_hold_b"}, bus.ct_b, exp_b);
            end
            start = 1'b0;
        end
        bus.ct_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, bus.ct_valid, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_keep_a"}, bus.ct_a, exp_a);
        check({tag, "_keep_b"}, bus.ct_b, exp_b);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        kyber_k       = 3'd4;
        msg_bit       = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_in    = '0;
        bus.sum_in    = '0;
        bus.select    = 1'b0;
        bus.ct_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_ready", bus.row_ready, 0);
        check("rst_ct_valid", bus.ct_valid, 0);
        check("rst_ct_a", bus.ct_a, 0);
        check("rst_ct_b", bus.ct_b, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Full set, then Partial set started the cycle after the handshake.
        run_enc("full", 3'd4, 1'b0, 1'b0, 8'hFF, 1'b0, FULL_A, FULL_B);
        run_enc("partial", 3'd3, 1'b1, 1'b0, 8'h55, 1'b0, PART_A, PART_B);

        run_enc("wrap0", 3'd4, 1'b0, 1'b1, 8'hFF, 1'b0, WRAP_A, 16'hFFF8);
        run_enc("wrap1", 3'd4, 1'b1, 1'b1, 8'hFF, 1'b0, WRAP_A, 16'h7FF8);

        run_enc("bp", 3'd4, 1'b0, 1'b0, 8'hFF, 1'b1, FULL_A, FULL_B);

        // Reset after three accepted rows must clear outputs without waiting for a clock.
        do_start(3'd4, 1'b0);
        feed_rows(3, 1'b0, 8'hFF, 1'b0);
        check("mid_ct_a_nonzero", bus.ct_a != 0, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ct_a", bus.ct_a, 0);
        check("mid_rst_ct_b", bus.ct_b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_row_ready", bus.row_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_enc("after_rst", 3'd4, 1'b0, 1'b0, 8'hFF, 1'b0, FULL_A, FULL_B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
